// File: rtl/rob_commit.sv
// rob_commit: reorder-buffer entry store with in-order commit to register file or memory port
module rob_commit #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE = 8,
  parameter int RB_INDEX = 3,
  parameter int REG_INDEX = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic [REG_INDEX-1:0]          alloc_dest,
  input  logic                          alloc_is_store,
  output logic                          alloc_ready,
  output logic [RB_INDEX-1:0]           alloc_index,
  input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  input  logic [RB_SIZE-1:0]            CDB_data_valid,
  input  logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
  input  logic                          flush,
  input  logic                          store_ack,
  output logic                          commit_valid,
  output logic [RB_INDEX-1:0]           commit_index,
  output logic [REG_INDEX-1:0]          commit_dest,
  output logic [WORD_SIZE-1:0]          commit_data,
  output logic [WORD_SIZE-1:0]          commit_addr,
  output logic                          commit_is_store,
  output logic [RB_INDEX:0]             count,
  output logic                          empty
);
  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_STORE_WAIT = 1'b1;
  logic [RB_SIZE-1:0] busy, armed, done, is_store;
  logic [REG_INDEX-1:0] dest [RB_SIZE];
  logic [WORD_SIZE-1:0] data [RB_SIZE];
  logic [WORD_SIZE-1:0] addr [RB_SIZE];
  logic [RB_INDEX-1:0] head, tail;
  logic [0:0] state;
  logic do_alloc, head_ok, retire;
  assign alloc_ready = count != (RB_INDEX+1)'(RB_SIZE);
  assign empty = count == '0;
  assign alloc_index = tail;
  assign do_alloc = alloc_req && alloc_ready;
  assign head_ok = busy[head] && done[head];
  assign retire = state == S_RUN ? head_ok && !is_store[head] : store_ack;
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      busy <= '0;
      armed <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= S_RUN;
      commit_valid <= 1'b0;
      if (!reset) begin
        is_store <= '0;
        commit_index <= '0;
        commit_dest <= '0;
        commit_data <= '0;
        commit_addr <= '0;
        commit_is_store <= 1'b0;
        for (int i = 0; i < RB_SIZE; i++) begin
          dest[i] <= '0;
          data[i] <= '0;
          addr[i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < RB_SIZE; i++) begin
        if (busy[i] && !armed[i] && !CDB_data_valid[i]) armed[i] <= 1'b1;
        if (busy[i] && armed[i] && !done[i] && CDB_data_valid[i]) begin
          done[i] <= 1'b1;
          data[i] <= CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
          addr[i] <= CDB_data_addr[i*WORD_SIZE +: WORD_SIZE];
        end
      end
      if (retire) begin
        busy[head] <= 1'b0;
        head <= head + RB_INDEX'(1);
      end
      if (do_alloc) begin
        busy[tail] <= 1'b1;
        armed[tail] <= 1'b0;
        done[tail] <= 1'b0;
        is_store[tail] <= alloc_is_store;
        dest[tail] <= alloc_dest;
        tail <= tail + RB_INDEX'(1);
      end
      count <= count + (RB_INDEX+1)'(do_alloc) - (RB_INDEX+1)'(retire);
      if (state == S_RUN) begin
        commit_valid <= head_ok;
        if (head_ok) begin
          commit_index <= head;
          commit_dest <= dest[head];
          commit_data <= data[head];
          commit_addr <= addr[head];
          commit_is_store <= is_store[head];
          state <= is_store[head] ? S_STORE_WAIT : S_RUN;
        end
      end else if (store_ack) begin
        commit_valid <= 1'b0;
        state <= S_RUN;
      end
    end
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder-buffer entry store and in-order commit stage. It sits directly downstream of the CDB data controller: it consumes that block's per-entry `CDB_data_data`, `CDB_data_valid` and `CDB_data_addr` vectors, marks reorder-buffer entries complete, and retires them in program order to the register file (ALU/load results) or the memory port (stores). Issue logic allocates entries here and receives the reorder-buffer index that functional units later drive on `RB_index_bus`.

## Interface
Parameters:
- `WORD_SIZE`, 32: data/address width.
- `RB_SIZE`, 8: number of entries; must be a power of two.
- `RB_INDEX`, 3: log2(`RB_SIZE`).
- `REG_INDEX`, 5: destination register index width.

Ports:
- `clk`  in  1: single clock; all state updates on the posedge.
- `reset`  in  1: synchronous, active-low.
- `alloc_req`  in  1: issue requests an entry.
- `alloc_dest`  in  `REG_INDEX`: destination register of the allocated instruction.
- `alloc_is_store`  in  1: allocated instruction is a store.
- `alloc_ready`  out  1: an entry is free (count < `RB_SIZE`).
- `alloc_index`  out  `RB_INDEX`: index given to this cycle's allocation (the tail pointer).
- `CDB_data_data`  in  `WORD_SIZE*RB_SIZE`: per-entry result slots; entry i is at [i*WORD_SIZE +: WORD_SIZE].
- `CDB_data_valid`  in  `RB_SIZE`: per-entry result-valid flags.
- `CDB_data_addr`  in  `RB_SIZE*WORD_SIZE`: per-entry store address slots.
- `flush`  in  1: discard all entries.
- `store_ack`  in  1: memory accepted the presented store.
- `commit_valid`  out  1: a commit is presented.
- `commit_index`, `commit_dest`, `commit_data`, `commit_addr`, `commit_is_store`  out  `RB_INDEX` / `REG_INDEX` / `WORD_SIZE` / `WORD_SIZE` / 1: fields of the committed entry.
- `count`  out  `RB_INDEX+1`: number of occupied entries.
- `empty`  out  1: `count` == 0.

## Operation
- **Per-entry state:** `busy`, `armed`, `done`, `is_store`, `dest`, `data`, `addr`. `head` and `tail` pointers wrap modulo `RB_SIZE`.
- **Allocate:** when `alloc_req && alloc_ready`:
  - entry[`tail`] gets `busy=1`, `armed=0`, `done=0`, plus `dest` and `is_store` from the alloc inputs.
  - `tail` increments.
  - `alloc_req` while `!alloc_ready` is ignored.
- **Arming:**
  - The CDB flags are sticky, so a reused entry can still see the previous occupant's valid bit.
  - A busy entry with `armed=0` sets `armed=1` on any edge where `CDB_data_valid[i]=0`.
  - This works because a functional unit drives valid low when it starts on an index.
- **Capture:** on each edge, every entry with `busy && armed && !done && CDB_data_valid[i]` latches its data and addr slots and sets `done=1`. All entries are evaluated in parallel.
- **Commit FSM, states `S_RUN` and `S_STORE_WAIT`:**
  - `S_RUN`, entry[`head`] busy and done, not a store: at the next edge, drive `commit_valid=1` with that entry's fields for exactly one cycle. In the same edge, clear `busy` and increment `head`. Back-to-back commits are allowed at one per cycle.
  - `S_RUN`, entry[`head`] busy and done, and a store: at the next edge, drive `commit_valid=1` with the store fields and go to `S_STORE_WAIT`. `head` does not advance.
  - `S_STORE_WAIT`: hold `commit_valid` and all fields. On the edge where `store_ack=1` is sampled: drop `commit_valid`, clear `busy`, increment `head`, return to `S_RUN`. No new commit is issued in that same edge.
  - Otherwise: `commit_valid=0`.
- **count:** +1 on allocate, −1 on retire. Allocate and retire in the same edge leave it unchanged.
- **flush** (priority over alloc, capture, commit and ack):
  - clears every `busy`, `armed` and `done` bit;
  - sets `head = tail = count = 0`;
  - FSM returns to `S_RUN` and `commit_valid=0` after the edge;
  - a pending store is abandoned, and a `store_ack` in the flush cycle is ignored.
- **Reset:** same state effect as flush.
  - All outputs are 0 after the edge, except `alloc_ready=1` and `empty=1`.
  - `commit_*` fields reset to 0.
  - Data and addr storage also reset to 0.

## Timing
- Allocation is visible the next cycle: `count` +1, `alloc_index` advanced.
- `alloc_ready` and `empty` are combinational from `count`.
- The CDB updates on the negedge; this block samples on the following posedge, half a cycle later.
- Commit latency: CDB valid sampled at edge t sets `done`; the earliest `commit_valid` is after edge t+1.
- Full (count == `RB_SIZE`): `alloc_ready=0`, even if a retire happens in the same cycle. The freed slot is usable the following cycle.
- `head` passing `RB_SIZE-1` wraps to 0. `tail` wraps the same way.
- A store holds `S_STORE_WAIT` indefinitely without `store_ack`. `store_ack` outside `S_STORE_WAIT` is ignored.

## Test plan
- **Reset and basic commit:** with `reset=0` for 2 cycles, then allocate dest=5 at index 0. Hold `CDB_data_valid[0]=0` for one cycle, then 1 with slot 0 = 0x1234. Expect `commit_valid` for one cycle with index 0, dest 5, data 0x1234; afterwards `count`=0 and `empty`=1.
- **Stale valid masking:** leave `CDB_data_valid[0]=1` from a prior occupant and reallocate index 0. Expect no commit until valid has been low for one cycle and then high again.
- **Out-of-order completion:** allocate indices 0,1,2 and complete 2, then 1, then 0. Expect commits 0, 1, 2 on three consecutive cycles.
- **Store handshake:** allocate a store at index 0 and complete it with addr=0x40, data=0x99. Expect `commit_valid` held with `commit_is_store=1` for 3 cycles while `store_ack=0`. Assert `store_ack`; `commit_valid` drops next cycle and `head`=1.
- **Full and wrap-around:** fill 8 entries and check `alloc_ready=0` with `count`=8. Retire one: `alloc_ready` returns next cycle, the new allocation gets index 0, and commit order continues 1..7 then 0.
- **Flush mid-store:** during `S_STORE_WAIT`, assert `flush` and `store_ack` together. Expect `commit_valid=0`, `count`=0, `head`=`tail`=0 and no retire.
